// File: rtl/insn_encoder_pkg.sv
// Shared RISC-V definitions: major opcodes, instruction formats and the
// encoded-word buffer entry.
package insn_encoder_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } insn_fmt_e;

  typedef struct packed {
    logic [31:0] insn;
    logic        err;
  } insn_entry_t;

  function automatic insn_fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_OP:                      return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:   return FMT_I;
      OP_STORE:                   return FMT_S;
      OP_BRANCH:                  return FMT_B;
      OP_LUI, OP_AUIPC:           return FMT_U;
      OP_JAL:                     return FMT_J;
      default:                    return FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/insn_encoder_fifo.sv
// Small valid/ready circular buffer; outputs read as zero whenever the head
// is empty or the block is held in reset.
module insn_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [31:0]
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  // Readiness depends on the registered count only, so a full buffer never
  // accepts even when the head is leaving this cycle.
  assign in_ready  = !reset && (count < CW'(DEPTH));
  assign out_valid = !reset && (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/insn_encoder.sv
// RV32I instruction encoder: packs request fields into a 32-bit word, flags
// unrepresentable immediates, and buffers results through insn_fifo.
module insn_encoder
  import insn_encoder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [6:0]       opcode_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [31:0]      imm_i,
  output logic             insn_valid_o,
  input  logic             insn_ready_i,
  output logic [31:0]      insn_o,
  output logic             err_o,
  output logic [CNT_W-1:0] enc_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  insn_fmt_e   fmt;
  logic [31:0] word;
  logic        bad;
  insn_entry_t enc_entry;
  insn_entry_t head;
  logic        push;

  always_comb begin
    fmt  = fmt_of(opcode_i);
    word = '0;
    bad  = 1'b0;
    case (fmt)
      FMT_R: word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: begin
        word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        bad  = !((&imm_i[31:11]) || !(|imm_i[31:11]));
      end
      FMT_S: begin
        word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        bad  = !((&imm_i[31:11]) || !(|imm_i[31:11]));
      end
      FMT_B: begin
        word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                imm_i[4:1], imm_i[11], opcode_i};
        bad  = imm_i[0] || !((&imm_i[31:12]) || !(|imm_i[31:12]));
      end
      FMT_U: begin
        word = {imm_i[31:12], rd_i, opcode_i};
        bad  = |imm_i[11:0];
      end
      FMT_J: begin
        word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        bad  = imm_i[0] || !((&imm_i[31:20]) || !(|imm_i[31:20]));
      end
      default: begin
        word = '0;
        bad  = 1'b1;
      end
    endcase
    enc_entry.insn = word;
    enc_entry.err  = bad;
  end

  insn_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (insn_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (req_valid_i),
    .in_ready  (req_ready_o),
    .in_data   (enc_entry),
    .out_valid (insn_valid_o),
    .out_ready (insn_ready_i),
    .out_data  (head)
  );

  assign insn_o = head.insn;
  assign err_o  = head.err;
  assign push   = req_valid_i && req_ready_o;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_cnt_o <= '0;
      err_cnt_o <= '0;
    end else if (push) begin
      if (enc_cnt_o != '1)          enc_cnt_o <= enc_cnt_o + CNT_W'(1);
      if (bad && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 Parameter DEPTH, default 2: output buffer entries, at least 2.
REQ-002 Parameter CNT_W, default 16: width of the encode and error counters.
REQ-003 clk  in  1: single clock; all state updates on rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 req_valid_i  in  1: request fields below are valid this cycle.
REQ-006 req_ready_o  out  1: encoder accepts a request this cycle.
REQ-007 opcode_i  in  7: RV32I major opcode.
REQ-008 rd_i, rs1_i, rs2_i  in  5 each: register indices.
REQ-009 funct3_i  in  3; funct7_i  in  7: function fields.
REQ-010 imm_i  in  32: full-width immediate value, packed into the opcode's format.
REQ-011 insn_valid_o  out  1: buffer head holds an encoded word.
REQ-012 insn_ready_i  in  1: consumer takes the head this cycle.
REQ-013 insn_o  out  32: encoded instruction at the head.
REQ-014 err_o  out  1: head word has an unrepresentable immediate or an unknown opcode.
REQ-015 enc_cnt_o, err_cnt_o  out  CNT_W each: accepted-request count and errored-request count.

Function
REQ-016 Accept (push) when req_valid_i and req_ready_o; pop when insn_valid_o and insn_ready_i.
REQ-017 req_ready_o = (count < DEPTH), registered count only; no push-through when full, even if a pop occurs in the same cycle.
REQ-018 Latency: an accepted request appears at insn_o/err_o on the next cycle when the buffer was empty.
REQ-019 Output order equals acceptance order; head fields stay stable while insn_valid_o and not insn_ready_i.
REQ-020 Push and pop in the same cycle leave count unchanged; read/write pointers wrap modulo DEPTH.
REQ-021 Format selection by opcode: R 0110011; I 0010011, 0000011, 1100111; S 0100011; B 1100011; U 0110111, 0010111; J 1101111; any other opcode is unknown.
REQ-022 Bit packing is the exact inverse of the pipeline's immediate extraction: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12|10:5]->[31:25], imm[4:1|11]->[11:7]; U imm[31:12]->[31:12]; J imm[20|10:1|11|19:12]->[31:12].
REQ-023 rd/rs1/rs2/funct3/funct7 are packed only where the format defines them; all unused bit positions are 0.
REQ-024 Error rules:
  - I/S: imm_i[31:11] not all equal -> error.
  - B: imm_i[0]=1, or imm_i[31:12] not all equal -> error.
  - U: imm_i[11:0]!=0 -> error.
  - J: imm_i[0]=1, or imm_i[31:20] not all equal -> error.
  - R: imm_i is ignored and never raises an error.
REQ-025 On error, insn_o still carries the word packed from truncated fields and err_o=1; an unknown opcode yields insn_o=0, err_o=1.
REQ-026 enc_cnt_o increments on every push; err_cnt_o increments on every push that carries an error; both counters saturate at all-ones.

Reset
REQ-027 While reset=1: count, pointers and counters clear; insn_valid_o=0, req_ready_o=0, insn_o=0, err_o=0.
REQ-028 req_ready_o=1 on the first cycle after reset deasserts.
REQ-029 Reset mid-operation discards all buffered entries; no partial word is ever emitted.

Structure
REQ-030 Opcode constants, a format enum (R/I/S/B/U/J/NONE) and the buffer entry struct {insn, err} shall live in the shared RISC-V package used by the decode stage.
REQ-031 A sub-module insn_fifo (parameterised by DEPTH and entry type, valid/ready on both sides) holds the buffer; packing and range checks are combinational in insn_encoder.

Verification
REQ-032 opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 -> insn_o=0x00500093 one cycle later, err_o=0.
REQ-033 sw: opcode 0100011, funct3=010, rs1=1, rs2=2, imm=8 -> 0x0020A423; beq x0,x0 with imm=-4 -> 0xFE000EE3.
REQ-034 lui rd=5, imm=0x12345000 -> 0x123452B7; jal rd=1, imm=0x800 -> 0x001000EF.
REQ-035 addi imm=2048 -> err_o=1 and err_cnt_o increments; B-type imm=3 -> err_o=1; opcode 0x7F -> insn_o=0, err_o=1.
REQ-036 Backpressure: insn_ready_i=0, push A then B -> req_ready_o=0 and a held request C is not accepted; then insn_ready_i=1 -> A, B, C emitted in order.
REQ-037 Reset asserted with 2 entries buffered -> insn_valid_o=0 the next cycle; counters=0; no stale word appears after reset.
